spi_slave: RTL and testbench

SPI peripheral/target endpoint: the responder end of the SPI link driven by the team's SPI master. It oversamples the external SCLK, CS and MOSI with I_clk, deserialises MOSI into parallel words and serialises a preloaded word onto MISO. It supports back-to-back words under one CS assertion, and reports aborted frames and TX underrun.

---
 rtl/spi_slave.sv | 181 ++++++++++++++++++
 tb/tb_spi_slave.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI target endpoint: oversamples CS/SCLK/MOSI on I_clk, receives MSB-first words on MOSI
// and returns LSB-first words on MISO, with continuous-mode, underrun and aborted-frame reporting.
module spi_slave #(
  parameter int CPOL      = 0,
  parameter int CPHA      = 1,
  parameter int DATAWIDTH = 8
) (
  input  logic                 I_clk,
  input  logic                 I_rstn,
  input  logic [DATAWIDTH-1:0] I_send_data,
  input  logic                 I_send_valid,
  output logic                 O_tx_ready,
  output logic [DATAWIDTH-1:0] O_recv_data,
  output logic                 O_recv_valid,
  output logic                 O_busy,
  output logic                 O_tx_underrun,
  output logic                 O_frame_err,
  input  logic                 I_cs,
  input  logic                 I_sclk,
  input  logic                 I_mosi,
  output logic                 O_miso,
  output logic                 O_miso_oe
);

  localparam int            CW       = $clog2(DATAWIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATAWIDTH - 1);
  localparam logic          IDLE_LVL = 1'(CPOL);
  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_XFER  = 1'b1;

  logic [2:0]           cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                 lead_q, trail_q, cs_fall_q, cs_rise_q;
  logic [0:0]           state_q, state_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATAWIDTH-1:0] rx_q, rx_d;
  logic [DATAWIDTH-1:0] shift_q, shift_d;
  logic [DATAWIDTH-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 load_pend_q, load_pend_d;
  logic [DATAWIDTH-1:0] recv_data_q, recv_data_d;
  logic                 recv_valid_q, recv_valid_d;
  logic                 underrun_q, underrun_d;
  logic                 frame_err_q, frame_err_d;
  logic                 do_load;
  logic                 sample_edge, drive_edge;

  // Stage 2 is the previous value of stage 1, so edges are found between them and registered
  // once more; the FSM therefore acts one cycle after detection.
  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      cs_sync_q   <= 3'b111;
      sclk_sync_q <= {3{IDLE_LVL}};
      mosi_sync_q <= 3'b000;
      lead_q      <= 1'b0;
      trail_q     <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[1:0], I_cs};
      sclk_sync_q <= {sclk_sync_q[1:0], I_sclk};
      mosi_sync_q <= {mosi_sync_q[1:0], I_mosi};
      lead_q      <= (sclk_sync_q[1] != sclk_sync_q[2]) && (sclk_sync_q[2] == IDLE_LVL);
      trail_q     <= (sclk_sync_q[1] != sclk_sync_q[2]) && (sclk_sync_q[1] == IDLE_LVL);
      cs_fall_q   <= cs_sync_q[2] && !cs_sync_q[1];
      cs_rise_q   <= !cs_sync_q[2] && cs_sync_q[1];
    end
  end

  assign sample_edge = (CPHA == 0) ? lead_q : trail_q;
  assign drive_edge  = (CPHA == 0) ? trail_q : lead_q;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    load_pend_d  = load_pend_q;
    recv_data_d  = recv_data_q;
    recv_valid_d = 1'b0;
    underrun_d   = 1'b0;
    frame_err_d  = 1'b0;
    do_load      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall_q) begin
          state_d     = ST_XFER;
          bit_cnt_d   = '0;
          rx_d        = '0;
          load_pend_d = 1'b0;
          do_load     = 1'b1;
        end
      end
      ST_XFER: begin
        if (cs_rise_q) begin
          frame_err_d = (bit_cnt_q != '0);
          load_pend_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          if (sample_edge) begin
            rx_d = {rx_q[DATAWIDTH-2:0], mosi_sync_q[2]};
            if (bit_cnt_q == LAST_BIT) begin
              recv_data_d  = rx_d;
              recv_valid_d = 1'b1;
              bit_cnt_d    = '0;
              load_pend_d  = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          // With CPHA=1 the first leading edge of a word only presents bit 0, so it never shifts.
          if (drive_edge) begin
            if (load_pend_q) begin
              do_load     = 1'b1;
              load_pend_d = 1'b0;
            end else if ((CPHA == 0) || (bit_cnt_q != '0)) begin
              shift_d = shift_q >> 1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_load) begin
      if (hold_full_q) begin
        shift_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        shift_d    = '0;
        underrun_d = 1'b1;
      end
    end

    // A write in the same cycle as an underrun load is kept for the following word.
    if (I_send_valid && !hold_full_q) begin
      hold_d      = I_send_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      rx_q         <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      load_pend_q  <= 1'b0;
      recv_data_q  <= '0;
      recv_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      load_pend_q  <= load_pend_d;
      recv_data_q  <= recv_data_d;
      recv_valid_q <= recv_valid_d;
      underrun_q   <= underrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign O_busy        = (state_q == ST_XFER);
  assign O_miso        = O_busy & shift_q[0];
  assign O_miso_oe     = O_busy;
  assign O_tx_ready    = !hold_full_q;
  assign O_recv_data   = recv_data_q;
  assign O_recv_valid  = recv_valid_q;
  assign O_tx_underrun = underrun_q;
  assign O_frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per CPOL/CPHA mode (index = CPOL*2+CPHA), driven by a
// master-side BFM; expected words come from what the master sent and what the slave was given.
module tb_spi_slave;

  localparam int W    = 8;
  localparam int HALF = 8;

  logic         clk = 1'b0;
  logic         rstn;
  logic [3:0]   cs, sclk, sendValid, txReady, recvValid, busy, underrun, frameErr, miso, misoOe;
  logic [W-1:0] sendData;
  logic         mosi;
  logic [W-1:0] recvData [4];

  int checks   = 0;
  int failures = 0;
  int underrunCount [4] = '{default: 0};
  int frameErrCount [4] = '{default: 0};
  logic [W+1:0] recvQ [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gDut
    spi_slave #(.CPOL(g / 2), .CPHA(g % 2), .DATAWIDTH(W)) u_dut (
      .I_clk        (clk),
      .I_rstn       (rstn),
      .I_send_data  (sendData),
      .I_send_valid (sendValid[g]),
      .O_tx_ready   (txReady[g]),
      .O_recv_data  (recvData[g]),
      .O_recv_valid (recvValid[g]),
      .O_busy       (busy[g]),
      .O_tx_underrun(underrun[g]),
      .O_frame_err  (frameErr[g]),
      .I_cs         (cs[g]),
      .I_sclk       (sclk[g]),
      .I_mosi       (mosi),
      .O_miso       (miso[g]),
      .O_miso_oe    (misoOe[g])
    );
  end

  // Pulse monitor: logs every received word tagged with its mode, counts error pulses.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (recvValid[i] === 1'b1) recvQ.push_back({2'(i), recvData[i]});
      if (underrun[i] === 1'b1) underrunCount[i]++;
      if (frameErr[i] === 1'b1) frameErrCount[i]++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic writeWord(input int m, input logic [W-1:0] w);
    @(negedge clk);
    sendData     = w;
    sendValid[m] = 1'b1;
    @(negedge clk);
    sendValid[m] = 1'b0;
  endtask

  // Master BFM; abortBits != 0 raises CS after that many SCLK cycles.
  task automatic spiFrame(input int m, input int nWords, input logic [W-1:0] txW [3],
                          input int nJit, input logic [W-1:0] jitW [3], input int abortBits,
                          output logic [W-1:0] rxW [3]);
    logic cpol, cpha;
    int   bitsDone;
    bit   stop;
    cpol     = m[1];
    cpha     = m[0];
    bitsDone = 0;
    stop     = 1'b0;
    for (int k = 0; k < 3; k++) rxW[k] = '0;
    @(negedge clk);
    cs[m] = 1'b0;
    if (!cpha) mosi = txW[0][W-1];
    for (int k = 0; k < nWords && !stop; k++) begin
      for (int b = 0; b < W && !stop; b++) begin
        repeat (HALF) @(negedge clk);
        if (!cpha) rxW[k][b] = miso[m];
        else mosi = txW[k][W-1-b];
        sclk[m] = ~cpol;
        if (b == 1 && k + 1 < nJit) begin
          writeWord(m, jitW[k+1]);
          repeat (HALF - 2) @(negedge clk);
        end else begin
          repeat (HALF) @(negedge clk);
        end
        if (cpha) rxW[k][b] = miso[m];
        sclk[m] = cpol;
        if (!cpha) begin
          if (b < W - 1) mosi = txW[k][W-2-b];
          else if (k + 1 < nWords) mosi = txW[k+1][W-1];
        end
        bitsDone++;
        if (abortBits != 0 && bitsDone == abortBits) stop = 1'b1;
      end
    end
    repeat (HALF) @(negedge clk);
    cs[m] = 1'b1;
    repeat (3 * HALF) @(negedge clk);
  endtask

  task automatic test_reset;
    rstn      = 1'b0;
    cs        = 4'hF;
    sclk      = 4'b1100;
    mosi      = 1'b0;
    sendValid = 4'h0;
    sendData  = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (txReady !== 4'hF) begin failures++; $display("[TB] FAIL reset_tx_ready: got %b, required 1111", txReady); end
    checks++; if (recvData[1] !== 8'h00) begin failures++; $display("[TB] FAIL reset_recv_data: got %h, required 00", recvData[1]); end
    checks++; if (recvValid !== 4'h0) begin failures++; $display("[TB] FAIL reset_recv_valid: got %b, required 0000", recvValid); end
    checks++; if (busy !== 4'h0) begin failures++; $display("[TB] FAIL reset_busy: got %b, required 0000", busy); end
    checks++; if (underrun !== 4'h0) begin failures++; $display("[TB] FAIL reset_underrun: got %b, required 0000", underrun); end
    checks++; if (frameErr !== 4'h0) begin failures++; $display("[TB] FAIL reset_frame_err: got %b, required 0000", frameErr); end
    checks++; if (miso !== 4'h0) begin failures++; $display("[TB] FAIL reset_miso: got %b, required 0000", miso); end
    checks++; if (misoOe !== 4'h0) begin failures++; $display("[TB] FAIL reset_miso_oe: got %b, required 0000", misoOe); end
  endtask

  task automatic test_basic;
    logic [W-1:0] tx [3], jit [3], got [3];
    tx  = '{8'h3C, 8'h00, 8'h00};
    jit = '{8'h00, 8'h00, 8'h00};
    recvQ.delete();
    writeWord(1, 8'hA5);
    checks++; if (txReady[1] !== 1'b0) begin failures++; $display("[TB] FAIL basic_ready_after_write: got %b, required 0", txReady[1]); end
    spiFrame(1, 1, tx, 0, jit, 0, got);
    checks++; if (recvQ.size() != 1) begin failures++; $display("[TB] FAIL basic_recv_count: got %0d, required 1", recvQ.size()); end
    else begin checks++; if (recvQ[0] !== {2'd1, 8'h3C}) begin failures++; $display("[TB] FAIL basic_recv_data: got %h, required 13c", recvQ[0]); end end
    checks++; if (got[0] !== 8'hA5) begin failures++; $display("[TB] FAIL basic_miso_word: got %h, required a5", got[0]); end
    checks++; if (txReady[1] !== 1'b1) begin failures++; $display("[TB] FAIL basic_ready_after_frame: got %b, required 1", txReady[1]); end
  endtask

  task automatic test_tx_full;
    logic [W-1:0] tx [3], jit [3], got [3];
    logic [W-1:0] first, second;
    first  = 8'($urandom);
    second = ~first;
    tx     = '{8'($urandom), 8'h00, 8'h00};
    jit    = '{8'h00, 8'h00, 8'h00};
    writeWord(1, first);
    writeWord(1, second);
    spiFrame(1, 1, tx, 0, jit, 0, got);
    checks++; if (got[0] !== first) begin failures++; $display("[TB] FAIL txfull_held_word: got %h, required %h", got[0], first); end
  endtask

  task automatic test_modes;
    logic [W-1:0] tx [3], jit [3], got [3];
    logic [W-1:0] slaveW;
    jit = '{8'h00, 8'h00, 8'h00};
    for (int m = 0; m < 4; m++) begin
      for (int rep = 0; rep < 3; rep++) begin
        slaveW = (rep == 0) ? 8'h81 : 8'($urandom);
        tx     = '{(rep == 0) ? 8'h7E : 8'($urandom), 8'h00, 8'h00};
        recvQ.delete();
        writeWord(m, slaveW);
        spiFrame(m, 1, tx, 0, jit, 0, got);
        checks++; if (recvQ.size() != 1 || recvQ[0] !== {2'(m), tx[0]}) begin
          failures++; $display("[TB] FAIL mode%0d_recv: got count %0d first %h, required count 1 word %h", m, recvQ.size(), (recvQ.size() > 0) ? recvQ[0] : '0, {2'(m), tx[0]});
        end
        checks++; if (got[0] !== slaveW) begin failures++; $display("[TB] FAIL mode%0d_miso: got %h, required %h", m, got[0], slaveW); end
      end
    end
  endtask

  task automatic test_underrun;
    logic [W-1:0] tx [3], jit [3], got [3];
    int uBase;
    tx    = '{8'h55, 8'h00, 8'h00};
    jit   = '{8'h00, 8'h00, 8'h00};
    recvQ.delete();
    uBase = underrunCount[1];
    spiFrame(1, 1, tx, 0, jit, 0, got);
    checks++; if (underrunCount[1] - uBase != 1) begin failures++; $display("[TB] FAIL underrun_pulses: got %0d, required 1", underrunCount[1] - uBase); end
    checks++; if (got[0] !== 8'h00) begin failures++; $display("[TB] FAIL underrun_miso: got %h, required 00", got[0]); end
    checks++; if (recvQ.size() != 1 || recvQ[0] !== {2'd1, 8'h55}) begin failures++; $display("[TB] FAIL underrun_recv: got count %0d, required one word 155", recvQ.size()); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] tx [3], jit [3], got [3];
    int uBase;
    tx    = '{8'h11, 8'h22, 8'h33};
    jit   = '{8'hA1, 8'hB2, 8'hC3};
    recvQ.delete();
    uBase = underrunCount[1];
    writeWord(1, jit[0]);
    spiFrame(1, 3, tx, 3, jit, 0, got);
    checks++; if (recvQ.size() != 3) begin failures++; $display("[TB] FAIL b2b_recv_count: got %0d, required 3", recvQ.size()); end
    else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (recvQ[k] !== {2'd1, tx[k]}) begin failures++; $display("[TB] FAIL b2b_recv_word%0d: got %h, required %h", k, recvQ[k], {2'd1, tx[k]}); end
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (got[k] !== jit[k]) begin failures++; $display("[TB] FAIL b2b_miso_word%0d: got %h, required %h", k, got[k], jit[k]); end
    end
    checks++; if (underrunCount[1] != uBase) begin failures++; $display("[TB] FAIL b2b_underrun: got %0d pulses, required 0", underrunCount[1] - uBase); end
  endtask

  task automatic test_frame_err;
    logic [W-1:0] tx [3], jit [3], got [3];
    int feBase;
    tx     = '{8'($urandom), 8'h00, 8'h00};
    jit    = '{8'h00, 8'h00, 8'h00};
    recvQ.delete();
    feBase = frameErrCount[1];
    writeWord(1, 8'($urandom));
    spiFrame(1, 1, tx, 0, jit, 5, got);
    checks++; if (frameErrCount[1] - feBase != 1) begin failures++; $display("[TB] FAIL frame_err_pulses: got %0d, required 1", frameErrCount[1] - feBase); end
    checks++; if (recvQ.size() != 0) begin failures++; $display("[TB] FAIL frame_err_recv: got %0d words, required 0", recvQ.size()); end
    checks++; if (busy[1] !== 1'b0) begin failures++; $display("[TB] FAIL frame_err_busy: got %b, required 0", busy[1]); end
    tx = '{8'($urandom), 8'h00, 8'h00};
    jit[0] = 8'($urandom);
    writeWord(1, jit[0]);
    spiFrame(1, 1, tx, 0, jit, 0, got);
    checks++; if (recvQ.size() != 1 || recvQ[0] !== {2'd1, tx[0]}) begin failures++; $display("[TB] FAIL frame_err_next_recv: got count %0d, required one word %h", recvQ.size(), tx[0]); end
    checks++; if (got[0] !== jit[0]) begin failures++; $display("[TB] FAIL frame_err_next_miso: got %h, required %h", got[0], jit[0]); end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] tx [3], jit [3], got [3];
    writeWord(1, 8'h5A);
    @(negedge clk); cs[1] = 1'b0;
    for (int e = 0; e < 3; e++) begin
      repeat (HALF) @(negedge clk); mosi = e[0]; sclk[1] = 1'b1;
      repeat (HALF) @(negedge clk); sclk[1] = 1'b0;
    end
    checks++; if (busy[1] !== 1'b1) begin failures++; $display("[TB] FAIL midreset_busy_before: got %b, required 1", busy[1]); end
    rstn = 1'b0;
    #1;
    checks++; if ({busy[1], misoOe[1], miso[1], txReady[1], recvValid[1]} !== 5'b00010) begin
      failures++; $display("[TB] FAIL midreset_outputs: got busy/oe/miso/ready/valid %b, required 00010", {busy[1], misoOe[1], miso[1], txReady[1], recvValid[1]});
    end
    checks++; if (recvData[1] !== 8'h00) begin failures++; $display("[TB] FAIL midreset_recv_data: got %h, required 00", recvData[1]); end
    cs[1] = 1'b1; sclk[1] = 1'b0; mosi = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    recvQ.delete();
    tx  = '{8'($urandom), 8'h00, 8'h00};
    jit = '{8'($urandom), 8'h00, 8'h00};
    writeWord(1, jit[0]);
    spiFrame(1, 1, tx, 0, jit, 0, got);
    checks++; if (recvQ.size() != 1 || recvQ[0] !== {2'd1, tx[0]}) begin failures++; $display("[TB] FAIL midreset_next_recv: got count %0d, required one word %h", recvQ.size(), tx[0]); end
    checks++; if (got[0] !== jit[0]) begin failures++; $display("[TB] FAIL midreset_next_miso: got %h, required %h", got[0], jit[0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tx_full();
    test_modes();
    test_underrun();
    test_back_to_back();
    test_frame_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
